// File: rtl/ddr3_pll_reset_sequencer_if.sv
// Signal bundle between the reset sequencer, the PHY PLL / IDELAYCTRL and the DDR3 controller.
// The master side drives the PLL status flags; the slave (sequencer) drives the resets and debug outputs.
interface ddr3_pll_reset_sequencer_if;
    logic       i_pll_locked;
    logic       i_idelayctrl_rdy;
    logic       o_pll_reset;
    logic       o_idelayctrl_rst;
    logic       o_controller_rst_n;
    logic [2:0] o_state;
    logic       o_fault;
    logic [7:0] o_relock_count;

    modport master (
        output i_pll_locked,
        output i_idelayctrl_rdy,
        input  o_pll_reset,
        input  o_idelayctrl_rst,
        input  o_controller_rst_n,
        input  o_state,
        input  o_fault,
        input  o_relock_count
    );

    modport slave (
        input  i_pll_locked,
        input  i_idelayctrl_rdy,
        output o_pll_reset,
        output o_idelayctrl_rst,
        output o_controller_rst_n,
        output o_state,
        output o_fault,
        output o_relock_count
    );
endinterface

// File: rtl/ddr3_pll_reset_sequencer.sv
// Orders PLL reset, IDELAYCTRL reset and DDR3 controller reset release on the free-running board clock,
// watching for lock loss, ready timeouts and relock events.
module ddr3_pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 8,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int IDELAY_RST_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES     = 65536
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    ddr3_pll_reset_sequencer_if.slave bus
);

    localparam int MAX_A     = (PLL_RST_CYCLES > IDELAY_RST_CYCLES) ? PLL_RST_CYCLES : IDELAY_RST_CYCLES;
    localparam int DWELL_MAX = (TIMEOUT_CYCLES > MAX_A) ? TIMEOUT_CYCLES : MAX_A;
    localparam int DW        = (DWELL_MAX > 2) ? $clog2(DWELL_MAX) : 1;
    localparam int SW        = (LOCK_STABLE_CYCLES > 2) ? $clog2(LOCK_STABLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_PLL_RST    = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_IDELAY_RST = 3'd2,
        S_WAIT_RDY   = 3'd3,
        S_RUN        = 3'd4
    } state_e;

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] rdy_sync_q;
    logic                   locked_s;
    logic                   rdy_s;

    state_e       state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [SW-1:0] stable_q, stable_d;
    logic          fault_q, fault_d;
    logic [7:0]    relock_q, relock_d;
    logic          pll_reset_q;
    logic          idelay_rst_q;
    logic          ctrl_rst_n_q;

    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lock_sync_q <= '0;
            rdy_sync_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.i_pll_locked};
            rdy_sync_q  <= {rdy_sync_q[SYNC_STAGES-2:0], bus.i_idelayctrl_rdy};
        end
    end

    assign locked_s = lock_sync_q[SYNC_STAGES-1];
    assign rdy_s    = rdy_sync_q[SYNC_STAGES-1];

    // NOTE: every always_comb target takes a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q + 1'b1;
        stable_d = stable_q;
        fault_d  = fault_q;
        relock_d = relock_q;

        unique case (state_q)
            S_PLL_RST: begin
                if (dwell_q == DW'(PLL_RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (dwell_q == DW'(TIMEOUT_CYCLES - 1)) begin
                    fault_d = 1'b1;
                    state_d = S_PLL_RST;
                end else if (!locked_s) begin
                    stable_d = '0;
                end else if (stable_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = S_IDELAY_RST;
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end
            S_IDELAY_RST: begin
                if (!locked_s) state_d = S_PLL_RST;
                else if (dwell_q == DW'(IDELAY_RST_CYCLES - 1)) state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (!locked_s) begin
                    state_d = S_PLL_RST;
                end else if (dwell_q == DW'(TIMEOUT_CYCLES - 1)) begin
                    fault_d = 1'b1;
                    state_d = S_PLL_RST;
                end else if (rdy_s) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                    state_d = S_PLL_RST;
                end else if (!rdy_s) begin
                    state_d = S_IDELAY_RST;
                end
            end
            default: state_d = S_PLL_RST;
        endcase

        // Both counters restart on every state entry.
        if (state_d != state_q) begin
            dwell_d  = '0;
            stable_d = '0;
        end
    end

    // Reset outputs decode the next state so they switch on the same edge as the state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_PLL_RST;
            dwell_q      <= '0;
            stable_q     <= '0;
            fault_q      <= 1'b0;
            relock_q     <= 8'd0;
            pll_reset_q  <= 1'b1;
            idelay_rst_q <= 1'b1;
            ctrl_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            stable_q     <= stable_d;
            fault_q      <= fault_d;
            relock_q     <= relock_d;
            pll_reset_q  <= (state_d == S_PLL_RST);
            idelay_rst_q <= (state_d == S_PLL_RST) || (state_d == S_WAIT_LOCK) || (state_d == S_IDELAY_RST);
            ctrl_rst_n_q <= (state_d == S_RUN);
        end
    end

    assign bus.o_pll_reset        = pll_reset_q;
    assign bus.o_idelayctrl_rst   = idelay_rst_q;
    assign bus.o_controller_rst_n = ctrl_rst_n_q;
    assign bus.o_state            = state_q;
    assign bus.o_fault            = fault_q;
    assign bus.o_relock_count     = relock_q;

endmodule

// File: tb/tb_ddr3_pll_reset_sequencer.sv
// Bench for ddr3_pll_reset_sequencer: randomized bring-up, glitch, timeout, relock and reset scenarios
// checked against tick arithmetic derived from the sequencing rules.
module tb_ddr3_pll_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int PLL    = 8;
    localparam int STABLE = 64;
    localparam int IDLY   = 16;
    localparam int TMO    = 1024;

    localparam logic [14:0] RESET_V = {1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   t = 0;

    always #5 clk = ~clk;

    ddr3_pll_reset_sequencer_if bus ();

    ddr3_pll_reset_sequencer #(
        .SYNC_STAGES       (SYNC),
        .PLL_RST_CYCLES    (PLL),
        .LOCK_STABLE_CYCLES(STABLE),
        .IDELAY_RST_CYCLES (IDLY),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // Release order must hold on every cycle of every scenario.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.o_controller_rst_n === 1'b1 && (bus.o_pll_reset !== 1'b0 || bus.o_idelayctrl_rst !== 1'b0)) begin
                errors++;
                $display("FAIL release_order: ctrl_rst_n=%b pll_reset=%b idelay_rst=%b at t=%0d",
                         bus.o_controller_rst_n, bus.o_pll_reset, bus.o_idelayctrl_rst, t);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] outs();
        return {bus.o_pll_reset, bus.o_idelayctrl_rst, bus.o_controller_rst_n,
                bus.o_state, bus.o_fault, bus.o_relock_count};
    endfunction

    // Tick at which state 2 is first observed, given the tick lock was raised (0 = already high at release).
    function automatic int exp_idelay_entry(input int lock_t);
        int first_high;
        first_high = (lock_t + SYNC + 1 > PLL + 1) ? lock_t + SYNC + 1 : PLL + 1;
        return first_high + STABLE - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic apply_reset(input logic lock, input logic rdy);
        rst_n = 1'b0;
        bus.i_pll_locked     = lock;
        bus.i_idelayctrl_rdy = rdy;
        repeat (3) tick();
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic wait_for_state(input logic [2:0] st, input int budget);
        int n = 0;
        while (bus.o_state !== st && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        apply_reset(1'b1, 1'b1);
        checks++;
        if (outs() !== RESET_V) begin
            errors++;
            $display("FAIL reset_hold: outs=%h expected %h", outs(), RESET_V);
        end
        tick();
        checks++;
        if (outs() !== RESET_V) begin
            errors++;
            $display("FAIL reset_first_cycle: outs=%h expected %h", outs(), RESET_V);
        end
    endtask

    task automatic test_clean_bringup();
        int lock_t  = int'($urandom_range(90, 110));
        int rdy_gap = int'($urandom_range(40, 60));
        int fall_t  = -1;
        int e2, e3;
        apply_reset(1'b0, 1'b0);
        while (t < lock_t) begin
            tick();
            if (fall_t < 0 && bus.o_pll_reset === 1'b0) fall_t = t;
        end
        bus.i_pll_locked = 1'b1;
        checks++;
        if (fall_t != PLL) begin
            errors++;
            $display("FAIL bringup_pll_pulse: pll_reset high %0d cycles, expected %0d", fall_t, PLL);
        end
        wait_for_state(3'd2, 2 * STABLE + 40);
        e2 = t;
        checks++;
        if (bus.o_state !== 3'd2 || e2 != exp_idelay_entry(lock_t)) begin
            errors++;
            $display("FAIL bringup_idelay_entry: state=%0d at t=%0d, expected state 2 at t=%0d",
                     bus.o_state, e2, exp_idelay_entry(lock_t));
        end
        checks++;
        if (bus.o_pll_reset !== 1'b0 || bus.o_idelayctrl_rst !== 1'b1) begin
            errors++;
            $display("FAIL bringup_state2_outs: pll_reset=%b idelay_rst=%b, expected 0 1",
                     bus.o_pll_reset, bus.o_idelayctrl_rst);
        end
        wait_for_state(3'd3, IDLY + 10);
        e3 = t;
        checks++;
        if (bus.o_state !== 3'd3 || e3 - e2 != IDLY || bus.o_idelayctrl_rst !== 1'b0) begin
            errors++;
            $display("FAIL bringup_idelay_pulse: state=%0d idelay_rst=%b after %0d cycles in state 2, expected 3 0 %0d",
                     bus.o_state, bus.o_idelayctrl_rst, e3 - e2, IDLY);
        end
        repeat (rdy_gap) tick();
        bus.i_idelayctrl_rdy = 1'b1;
        wait_for_state(3'd4, SYNC + 10);
        checks++;
        if (bus.o_state !== 3'd4 || t != e3 + rdy_gap + SYNC + 1) begin
            errors++;
            $display("FAIL bringup_run_entry: state=%0d at t=%0d, expected state 4 at t=%0d",
                     bus.o_state, t, e3 + rdy_gap + SYNC + 1);
        end
        checks++;
        if (outs() !== {1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL bringup_run_outs: outs=%h expected %h", outs(), {1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'd0});
        end
    endtask

    task automatic test_lock_glitch();
        int g  = int'($urandom_range(STABLE / 4, 3 * STABLE / 4));
        int tg = g + PLL - SYNC;
        apply_reset(1'b1, 1'b0);
        while (t < tg) tick();
        bus.i_pll_locked = 1'b0;
        tick();
        bus.i_pll_locked = 1'b1;
        wait_for_state(3'd2, 4 * STABLE);
        checks++;
        if (bus.o_state !== 3'd2 || t != tg + SYNC + 1 + STABLE) begin
            errors++;
            $display("FAIL lock_glitch: state=%0d at t=%0d, expected state 2 at t=%0d (glitch at count %0d)",
                     bus.o_state, t, tg + SYNC + 1 + STABLE, g);
        end
    endtask

    task automatic test_lock_timeout();
        int fault_t = -1;
        int back_t  = -1;
        apply_reset(1'b1, 1'b0);
        while (back_t < 0 && t < PLL + TMO + 50) begin
            bus.i_pll_locked = (t % (STABLE / 2)) != 0;
            tick();
            if (fault_t < 0 && bus.o_fault === 1'b1) fault_t = t;
            if (t > PLL && bus.o_state === 3'd0) back_t = t;
        end
        bus.i_pll_locked = 1'b1;
        checks++;
        if (fault_t != PLL + TMO || back_t != PLL + TMO) begin
            errors++;
            $display("FAIL lock_timeout: fault at t=%0d, state 0 at t=%0d, expected both at t=%0d",
                     fault_t, back_t, PLL + TMO);
        end
    endtask

    task automatic test_rdy_timeout();
        int e3, e0;
        apply_reset(1'b1, 1'b0);
        wait_for_state(3'd3, PLL + 2 * STABLE + IDLY + 20);
        e3 = t;
        checks++;
        if (bus.o_state !== 3'd3 || e3 != exp_idelay_entry(0) + IDLY) begin
            errors++;
            $display("FAIL rdy_wait_entry: state=%0d at t=%0d, expected state 3 at t=%0d",
                     bus.o_state, e3, exp_idelay_entry(0) + IDLY);
        end
        wait_for_state(3'd0, TMO + 10);
        e0 = t;
        checks++;
        if (bus.o_state !== 3'd0 || e0 - e3 != TMO || bus.o_fault !== 1'b1) begin
            errors++;
            $display("FAIL rdy_timeout: state=%0d fault=%b after %0d cycles in state 3, expected 0 1 %0d",
                     bus.o_state, bus.o_fault, e0 - e3, TMO);
        end
        wait_for_state(3'd1, PLL + 5);
        checks++;
        if (bus.o_state !== 3'd1 || t - e0 != PLL || bus.o_fault !== 1'b1) begin
            errors++;
            $display("FAIL rdy_timeout_restart: state=%0d fault=%b after %0d cycles, expected 1 1 %0d",
                     bus.o_state, bus.o_fault, t - e0, PLL);
        end
        bus.i_idelayctrl_rdy = 1'b1;
        wait_for_state(3'd4, PLL + 2 * STABLE + IDLY + 40);
        checks++;
        if (bus.o_state !== 3'd4 || bus.o_fault !== 1'b1 || bus.o_controller_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL fault_sticky: state=%0d fault=%b ctrl_rst_n=%b, expected 4 1 1",
                     bus.o_state, bus.o_fault, bus.o_controller_rst_n);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (outs() !== RESET_V) begin
            errors++;
            $display("FAIL fault_clear: outs=%h expected %h", outs(), RESET_V);
        end
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic test_rdy_drop_run();
        int   e2;
        logic pll_seen = 1'b0;
        apply_reset(1'b1, 1'b1);
        wait_for_state(3'd4, PLL + 2 * STABLE + IDLY + 40);
        checks++;
        if (bus.o_state !== 3'd4 || t != exp_idelay_entry(0) + IDLY + 1) begin
            errors++;
            $display("FAIL fast_release: state=%0d at t=%0d, expected state 4 at t=%0d",
                     bus.o_state, t, exp_idelay_entry(0) + IDLY + 1);
        end
        repeat ($urandom_range(1, 10)) tick();
        bus.i_idelayctrl_rdy = 1'b0;
        repeat (SYNC) begin
            tick();
            pll_seen |= bus.o_pll_reset;
        end
        checks++;
        if (bus.o_state !== 3'd4) begin
            errors++;
            $display("FAIL rdy_drop_early: state=%0d, expected 4 before %0d cycles", bus.o_state, SYNC + 1);
        end
        tick();
        e2 = t;
        checks++;
        if (bus.o_state !== 3'd2 || bus.o_relock_count !== 8'd0 || bus.o_controller_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL rdy_drop: state=%0d relock=%0d ctrl_rst_n=%b, expected 2 0 0",
                     bus.o_state, bus.o_relock_count, bus.o_controller_rst_n);
        end
        bus.i_idelayctrl_rdy = 1'b1;
        while (bus.o_state !== 3'd4 && t - e2 < IDLY + 20) begin
            tick();
            pll_seen |= bus.o_pll_reset;
        end
        checks++;
        if (bus.o_state !== 3'd4 || t - e2 != IDLY + 1) begin
            errors++;
            $display("FAIL rdy_recover: state=%0d after %0d cycles, expected 4 after %0d",
                     bus.o_state, t - e2, IDLY + 1);
        end
        checks++;
        if (pll_seen !== 1'b0) begin
            errors++;
            $display("FAIL rdy_drop_pll: pll_reset=%b during rdy recovery, expected 0", pll_seen);
        end
    endtask

    task automatic test_reset_mid_wait_rdy();
        apply_reset(1'b1, 1'b0);
        wait_for_state(3'd3, PLL + 2 * STABLE + IDLY + 20);
        repeat ($urandom_range(0, 20)) tick();
        checks++;
        if (bus.o_state !== 3'd3) begin
            errors++;
            $display("FAIL mid_rdy_setup: state=%0d, expected 3", bus.o_state);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (outs() !== RESET_V) begin
            errors++;
            $display("FAIL mid_rdy_reset: outs=%h expected %h", outs(), RESET_V);
        end
        rst_n = 1'b1;
        t = 0;
        tick();
        checks++;
        if (outs() !== RESET_V) begin
            errors++;
            $display("FAIL mid_rdy_release: outs=%h expected %h", outs(), RESET_V);
        end
    endtask

    task automatic test_back_to_back();
        int exp_cnt = 0;
        apply_reset(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            wait_for_state(3'd4, PLL + 2 * STABLE + IDLY + 40);
            checks++;
            if (bus.o_state !== 3'd4) begin
                errors++;
                $display("FAIL relock_run_%0d: state=%0d, expected 4", i, bus.o_state);
                break;
            end
            repeat ($urandom_range(0, 5)) tick();
            bus.i_pll_locked = 1'b0;
            repeat (SYNC) tick();
            checks++;
            if (bus.o_controller_rst_n !== 1'b1) begin
                errors++;
                $display("FAIL relock_early_%0d: ctrl_rst_n=%b after %0d cycles, expected 1", i,
                         bus.o_controller_rst_n, SYNC);
            end
            tick();
            checks++;
            if (bus.o_controller_rst_n !== 1'b0 || bus.o_state !== 3'd0) begin
                errors++;
                $display("FAIL relock_drop_%0d: ctrl_rst_n=%b state=%0d after %0d cycles, expected 0 0", i,
                         bus.o_controller_rst_n, bus.o_state, SYNC + 1);
            end
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            checks++;
            if (bus.o_relock_count !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL relock_count_%0d: count=%0d expected %0d", i, bus.o_relock_count, exp_cnt);
            end
            repeat ($urandom_range(0, 3)) tick();
            bus.i_pll_locked = 1'b1;
        end
    endtask

    task automatic test_reset_in_run();
        wait_for_state(3'd4, PLL + 2 * STABLE + IDLY + 40);
        checks++;
        if (bus.o_state !== 3'd4 || bus.o_relock_count !== 8'd255) begin
            errors++;
            $display("FAIL run_reset_setup: state=%0d relock=%0d, expected 4 255", bus.o_state, bus.o_relock_count);
        end
        rst_n = 1'b0;
        bus.i_pll_locked = 1'b0;
        tick();
        checks++;
        if (outs() !== RESET_V) begin
            errors++;
            $display("FAIL run_reset: outs=%h expected %h", outs(), RESET_V);
        end
        rst_n = 1'b1;
        t = 0;
    endtask

    initial begin
        bus.i_pll_locked     = 1'b0;
        bus.i_idelayctrl_rdy = 1'b0;
        test_reset();
        test_clean_bringup();
        test_lock_glitch();
        test_lock_timeout();
        test_rdy_timeout();
        test_rdy_drop_run();
        test_reset_mid_wait_rdy();
        test_back_to_back();
        test_reset_in_run();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
